// File: rtl/bitcell_array_ctrl.sv
// bitcell_array_ctrl: two-port arbiter and setup/pulse/hold sequencer for a NAND-latch bitcell array.
// Optional: define ARB_ROUND_ROBIN_EN for round-robin arbitration (fixed priority to requester 0 otherwise).
module bitcell_array_ctrl #(
    parameter int WORDS     = 8,
    parameter int WIDTH     = 4,
    parameter int ADDR_W    = 3,
    parameter int PULSE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [WIDTH-1:0]  req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [WIDTH-1:0]  req1_wdata,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic              rsp_err,
    output logic [WIDTH-1:0]  rsp_rdata,
    output logic [WORDS-1:0]  arr_sel,
    output logic              arr_r_w,
    output logic [WIDTH-1:0]  arr_in,
    input  logic [WIDTH-1:0]  arr_out
);
    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, SAMPLE, RESP} state_t;

    state_t state, state_nx;
    logic we_q, id_q, err_q, sel_on;
    logic [ADDR_W-1:0] addr_q, acc_addr;
    logic [WIDTH-1:0] wdata_q, rdata_q;
    logic [3:0] cnt;
    logic gnt0, gnt1, accept, win, acc_err;

`ifdef ARB_ROUND_ROBIN_EN
    logic ptr;
    assign gnt0 = state == IDLE && req0_valid && (!req1_valid || !ptr);
    assign gnt1 = state == IDLE && req1_valid && (!req0_valid || ptr);

    // ptr names the requester favoured on the next tie
    always_ff @(posedge clk or posedge rst)
        if (rst) ptr <= 1'b0;
        else if (accept) ptr <= !win;
`else
    assign gnt0 = state == IDLE && req0_valid;
    assign gnt1 = state == IDLE && req1_valid && !req0_valid;
`endif

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign accept     = gnt0 || gnt1;
    assign win        = gnt1;
    assign acc_addr   = win ? req1_addr : req0_addr;
    assign acc_err    = int'(acc_addr) >= WORDS;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:         if (accept) state_nx = acc_err ? RESP : SETUP;
            SETUP:        state_nx = we_q ? PULSE : SAMPLE;
            PULSE:        if (cnt == 4'd0) state_nx = HOLD;
            HOLD, SAMPLE: state_nx = RESP;
            default:      state_nx = IDLE;
        endcase
    end

    // Array drive is decoded from the state register so reset clears it without waiting for a clock
    assign sel_on    = state == SETUP || state == PULSE || state == HOLD || state == SAMPLE;
    assign arr_sel   = sel_on ? WORDS'(1) << addr_q : '0;
    assign arr_in    = sel_on && we_q ? wdata_q : '0;
    assign arr_r_w   = state == PULSE;
    assign rsp_valid = state == RESP;
    assign rsp_id    = rsp_valid && id_q;
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = rsp_valid ? rdata_q : '0;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            id_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt     <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                we_q    <= win ? req1_we : req0_we;
                addr_q  <= acc_addr;
                wdata_q <= win ? req1_wdata : req0_wdata;
                id_q    <= win;
                err_q   <= acc_err;
                rdata_q <= '0;
            end
            if (state == SETUP) cnt <= 4'(PULSE_CYC - 1);
            else if (state == PULSE) cnt <= cnt - 4'd1;
            if (state == SAMPLE) rdata_q <= arr_out;
        end
endmodule

// File: tb/tb_bitcell_array_ctrl.sv
// tb_bitcell_array_ctrl: randomized self-checking bench with a latch-array model and a transaction-level memory reference.
module tb_bitcell_array_ctrl;
    localparam int WORDS = 6, WIDTH = 4, ADDR_W = 3, PULSE_CYC = 2;
    localparam int WR_LAT = PULSE_CYC + 3, RD_LAT = 3, ER_LAT = 1;

    logic clk = 1'b0, rst = 1'b1;
    logic req0_valid = 0, req0_ready, req0_we = 0;
    logic [ADDR_W-1:0] req0_addr = '0;
    logic [WIDTH-1:0] req0_wdata = '0;
    logic req1_valid = 0, req1_ready, req1_we = 0;
    logic [ADDR_W-1:0] req1_addr = '0;
    logic [WIDTH-1:0] req1_wdata = '0;
    logic rsp_valid, rsp_id, rsp_err, arr_r_w;
    logic [WIDTH-1:0] rsp_rdata, arr_in, arr_out;
    logic [WORDS-1:0] arr_sel;

    int checks = 0, errors = 0;
    logic [WIDTH-1:0] cells [WORDS];
    logic [WIDTH-1:0] ref_mem [8];
    logic rr_next = 1'b0;

    bitcell_array_ctrl #(.WORDS(WORDS), .WIDTH(WIDTH), .ADDR_W(ADDR_W), .PULSE_CYC(PULSE_CYC)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .arr_sel(arr_sel), .arr_r_w(arr_r_w), .arr_in(arr_in), .arr_out(arr_out)
    );

    always #5 clk = ~clk;

    // Latch array: selected row follows arr_in while the strobe is high
    always @(posedge clk)
        if (arr_r_w)
            for (int i = 0; i < WORDS; i++)
                if (arr_sel[i]) cells[i] <= arr_in;

    always_comb begin
        arr_out = '0;
        for (int i = 0; i < WORDS; i++)
            if (arr_sel[i]) arr_out = arr_out | cells[i];
    end

    logic p_rw = 0;
    logic [WORDS-1:0] p_sel = '0;
    logic [WIDTH-1:0] p_in = '0;
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ((arr_r_w || p_rw) && (arr_sel !== p_sel || arr_in !== p_in)) begin
                errors++;
                $display("FAIL strobe_stable sel %b->%b in %h->%h rw %b->%b", p_sel, arr_sel, p_in, arr_in, p_rw, arr_r_w);
            end
            checks++;
            if ($countones(arr_sel) > 1) begin
                errors++;
                $display("FAIL sel_onehot sel=%b", arr_sel);
            end
        end
        p_rw = arr_r_w;
        p_sel = arr_sel;
        p_in = arr_in;
    end

    task automatic issue(input logic p, input logic we, input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d,
                         output int lat, output logic id, output logic err, output logic [WIDTH-1:0] rd,
                         output int sel_n, output int rw_n, output int rw_first, output logic [WORDS-1:0] sel_or);
        int w;
        lat = 0; id = 0; err = 0; rd = '0; sel_n = 0; rw_n = 0; rw_first = 0; sel_or = '0;
        @(negedge clk);
        if (p) begin req1_valid = 1; req1_we = we; req1_addr = a; req1_wdata = d; end
        else   begin req0_valid = 1; req0_we = we; req0_addr = a; req0_wdata = d; end
        #1;
        w = 0;
        while (!(p ? req1_ready : req0_ready) && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        @(negedge clk);
        req0_valid = 0;
        req1_valid = 0;
        for (int k = 1; k <= 30; k++) begin
            if (arr_sel != 0) sel_n++;
            sel_or = sel_or | arr_sel;
            if (arr_r_w) begin
                rw_n++;
                if (rw_first == 0) rw_first = k;
            end
            if (rsp_valid) begin
                lat = k; id = rsp_id; err = rsp_err; rd = rsp_rdata;
                break;
            end
            @(negedge clk);
        end
        rr_next = !p;
        if (we && int'(a) < WORDS) ref_mem[a] = d;
    endtask

    task automatic test_reset_state;
        checks++;
        if (arr_sel !== 0 || arr_r_w !== 0 || arr_in !== 0 || rsp_valid !== 0 || rsp_rdata !== 0 || rsp_id !== 0 || rsp_err !== 0) begin
            errors++;
            $display("FAIL reset_outputs sel=%b rw=%b in=%h rv=%b rd=%h id=%b err=%b expected all 0",
                     arr_sel, arr_r_w, arr_in, rsp_valid, rsp_rdata, rsp_id, rsp_err);
        end
        checks++;
        if (req0_ready !== 0 || req1_ready !== 0) begin
            errors++;
            $display("FAIL reset_ready r0=%b r1=%b expected 0 0", req0_ready, req1_ready);
        end
    endtask

    task automatic test_reset;
        int w, lat, sn, rn, rf;
        logic id, err, seen;
        logic [WIDTH-1:0] rd;
        logic [WORDS-1:0] so;
        @(negedge clk);
        req0_valid = 1; req0_we = 1; req0_addr = 3; req0_wdata = 4'b0110;
        @(negedge clk);
        req0_valid = 0;
        w = 0;
        while (!arr_r_w && w < 20) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (arr_r_w !== 1) begin
            errors++;
            $display("FAIL reset_reach_pulse rw=%b expected 1", arr_r_w);
        end
        rst = 1;
        #1;
        checks++;
        if (arr_r_w !== 0 || arr_sel !== 0 || rsp_valid !== 0) begin
            errors++;
            $display("FAIL reset_async rw=%b sel=%b rv=%b expected 0", arr_r_w, arr_sel, rsp_valid);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        req0_valid = 1; req0_we = 0; req0_addr = 0;
        #1;
        checks++;
        if (req0_ready !== 1) begin
            errors++;
            $display("FAIL reset_idle ready=%b expected 1", req0_ready);
        end
        req0_valid = 0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_no_rsp seen=%b expected 0", seen);
        end
        rr_next = 1'b0;
        issue(0, 1, 3, 4'h0, lat, id, err, rd, sn, rn, rf, so);
        checks++;
        if (lat != WR_LAT || err !== 0) begin
            errors++;
            $display("FAIL reset_rewrite lat=%0d err=%b expected %0d 0", lat, err, WR_LAT);
        end
    endtask

    task automatic test_write_read;
        int lat, sn, rn, rf;
        logic id, err;
        logic [WIDTH-1:0] rd;
        logic [WORDS-1:0] so;
        issue(0, 1, 5, 4'b1010, lat, id, err, rd, sn, rn, rf, so);
        checks++;
        if (lat != WR_LAT) begin errors++; $display("FAIL wr_latency got %0d expected %0d", lat, WR_LAT); end
        checks++;
        if (sn != PULSE_CYC + 2 || so !== 6'b100000) begin errors++; $display("FAIL wr_sel cycles=%0d sel=%b expected %0d 100000", sn, so, PULSE_CYC + 2); end
        checks++;
        if (rn != PULSE_CYC || rf != 2) begin errors++; $display("FAIL wr_strobe cycles=%0d first=%0d expected %0d 2", rn, rf, PULSE_CYC); end
        checks++;
        if (id !== 0 || err !== 0 || rd !== 0) begin errors++; $display("FAIL wr_rsp id=%b err=%b rd=%h expected 0 0 0", id, err, rd); end
        issue(0, 0, 5, 4'h0, lat, id, err, rd, sn, rn, rf, so);
        checks++;
        if (lat != RD_LAT) begin errors++; $display("FAIL rd_latency got %0d expected %0d", lat, RD_LAT); end
        checks++;
        if (rd !== 4'b1010 || err !== 0 || id !== 0) begin errors++; $display("FAIL rd_data rd=%h err=%b id=%b expected a 0 0", rd, err, id); end
        checks++;
        if (rn != 0) begin errors++; $display("FAIL rd_no_strobe cycles=%0d expected 0", rn); end
    endtask

    task automatic test_isolation;
        int lat, sn, rn, rf;
        logic id, err;
        logic [WIDTH-1:0] rd;
        logic [WORDS-1:0] so;
        issue(0, 1, 2, 4'b1111, lat, id, err, rd, sn, rn, rf, so);
        issue(1, 1, 3, 4'b0000, lat, id, err, rd, sn, rn, rf, so);
        issue(0, 0, 2, 4'h0, lat, id, err, rd, sn, rn, rf, so);
        checks++;
        if (rd !== 4'b1111) begin errors++; $display("FAIL iso_addr2 got %h expected f", rd); end
        issue(1, 0, 3, 4'h0, lat, id, err, rd, sn, rn, rf, so);
        checks++;
        if (rd !== 4'b0000 || id !== 1) begin errors++; $display("FAIL iso_addr3 got %h id=%b expected 0 1", rd, id); end
    endtask

    task automatic test_out_of_range;
        int lat, sn, rn, rf;
        logic id, err;
        logic [WIDTH-1:0] rd;
        logic [WORDS-1:0] so;
        for (int a = 6; a <= 7; a++) begin
            issue(0, a == 6, ADDR_W'(a), 4'hc, lat, id, err, rd, sn, rn, rf, so);
            checks++;
            if (lat != ER_LAT || err !== 1 || rd !== 0 || sn != 0 || rn != 0) begin
                errors++;
                $display("FAIL oor_addr%0d lat=%0d err=%b rd=%h sel_cycles=%0d rw=%0d expected %0d 1 0 0 0", a, lat, err, rd, sn, rn, ER_LAT);
            end
        end
    endtask

    task automatic test_contention;
        int n;
        logic exp_id;
        logic [ADDR_W-1:0] a0, a1;
        a0 = ADDR_W'($urandom_range(0, WORDS - 1));
        a1 = ADDR_W'($urandom_range(0, WORDS - 1));
        n = 0;
        @(negedge clk);
        req0_valid = 1; req0_we = 0; req0_addr = a0;
        req1_valid = 1; req1_we = 0; req1_addr = a1;
        for (int c = 0; c < 80 && n < 5; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
                exp_id = n >= 4 ? 1'b1 : rr_next ^ n[0];
`else
                exp_id = n >= 4;
`endif
                checks++;
                if (rsp_id !== exp_id || rsp_rdata !== ref_mem[exp_id ? a1 : a0]) begin
                    errors++;
                    $display("FAIL contention_%0d id=%b rd=%h expected %b %h", n, rsp_id, rsp_rdata, exp_id, ref_mem[exp_id ? a1 : a0]);
                end
                n++;
                if (n == 4) req0_valid = 0;
                if (n == 5) req1_valid = 0;
            end
        end
        req0_valid = 0;
        req1_valid = 0;
        checks++;
        if (n != 5) begin errors++; $display("FAIL contention_count got %0d expected 5", n); end
        rr_next = 1'b0;
    endtask

    task automatic test_random;
        int lat, sn, rn, rf, exp_lat;
        logic id, err, p, we, exp_err;
        logic [ADDR_W-1:0] a;
        logic [WIDTH-1:0] d, rd, exp_rd;
        logic [WORDS-1:0] so;
        for (int t = 0; t < 300; t++) begin
            p = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            a = ADDR_W'($urandom_range(0, 7));
            d = WIDTH'($urandom_range(0, 15));
            exp_err = int'(a) >= WORDS;
            exp_lat = exp_err ? ER_LAT : we ? WR_LAT : RD_LAT;
            exp_rd = (exp_err || we) ? '0 : ref_mem[a];
            issue(p, we, a, d, lat, id, err, rd, sn, rn, rf, so);
            checks++;
            if (lat != exp_lat || id !== p || err !== exp_err || rd !== exp_rd) begin
                errors++;
                $display("FAIL random_%0d we=%b a=%0d lat=%0d id=%b err=%b rd=%h expected %0d %b %b %h",
                         t, we, a, lat, id, err, rd, exp_lat, p, exp_err, exp_rd);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) cells[i] = '0;
        for (int i = 0; i < 8; i++) ref_mem[i] = '0;
        repeat (3) @(negedge clk);
        test_reset_state();
        rst = 0;
        test_reset();
        test_write_read();
        test_isolation();
        test_out_of_range();
        test_contention();
        test_random();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
